uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter CLK_FREQ, default 12_000_000, system clock frequency in Hz.
REQ-002: Parameter BAUD_RATE, default 115200, line bit rate in bits/s.
REQ-003: Parameter CLK_COUNT_BIT, default CLK_FREQ / BAUD_RATE (104), clocks per bit; HALF_BIT = CLK_COUNT_BIT / 2 (52).
REQ-004: clk  input  1  single system clock; all logic rising-edge.
REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006: RX  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007: rdata  output  8  last correctly framed byte, held until the next good byte.
REQ-008: rx_valid  output  1  one-cycle pulse, rdata updated this cycle.
REQ-009: data_ready  output  1  level, unread byte present in rdata.
REQ-010: rd_ack  input  1  consumer strobe, clears data_ready.
REQ-011: frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-012: overrun  output  1  one-cycle pulse, good byte landed while data_ready was still 1.
REQ-013: busy  output  1  high in every state except IDLE.

Function
REQ-014: RX shall pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s.
REQ-015: FSM states: IDLE, START, DATA, STOP, BREAK; one 32-bit clk_cnt and a 3-bit bit index.
REQ-016: IDLE: rx_s==0 -> START, clk_cnt=0; otherwise stay.
REQ-017: START: clk_cnt counts to HALF_BIT-1; there, rx_s==0 -> DATA, clk_cnt=0, index=0; rx_s==1 -> IDLE (glitch rejected, no outputs pulse).
REQ-018: DATA: at clk_cnt==CLK_COUNT_BIT-1 sample rx_s into shift[index], clk_cnt=0, index+1; sample at index 7 -> STOP.
REQ-019: STOP: at clk_cnt==CLK_COUNT_BIT-1, rx_s==1 -> rdata=shift, rx_valid=1, data_ready=1, IDLE; rx_s==0 -> frame_err=1, rdata unchanged, BREAK.
REQ-020: BREAK: stay until rx_s==1, then IDLE; a held-low line yields exactly one frame_err.
REQ-021: overrun pulses with rx_valid when data_ready is 1 at commit and rd_ack is 0; rdata is overwritten anyway.
REQ-022: rd_ack in the commit cycle: data_ready stays 1, overrun stays 0; rd_ack otherwise clears data_ready next edge; rd_ack while data_ready==0 is ignored.
REQ-023: Each data bit is sampled at mid-bit; rx_valid rises 2 + HALF_BIT + 9*CLK_COUNT_BIT clocks (+-1) after the RX falling edge.
REQ-024: rx_valid, frame_err, overrun never assert together with each other except rx_valid+overrun.
REQ-025: clk_cnt comparisons shall use 32-bit unsigned arithmetic; CLK_COUNT_BIT >= 4 is required.

Reset
REQ-026: rst_n low shall immediately force state=IDLE, clk_cnt=0, index=0, shift=0, rdata=8'h00, rx_valid=0, data_ready=0, frame_err=0, overrun=0, busy=0, sync flops=1.
REQ-027: Reset mid-frame discards the partial byte; after release the block waits for a fresh falling edge, sampling no bits of the interrupted frame as a start bit until rx_s has been seen high.

Verification
REQ-028: Drive 0xA5 at 104 clk/bit, stop=1 -> one rx_valid pulse, rdata=8'hA5, data_ready=1, frame_err=0.
REQ-029: RX low for 20 clocks then high -> no pulses, state back to IDLE, busy low within 55 clocks.
REQ-030: Drive 0x3C with stop bit 0 then hold RX low 2000 clocks -> exactly one frame_err, rdata unchanged, data_ready unchanged.
REQ-031: Send 0x11 then 0x22 without rd_ack -> second rx_valid with overrun=1, rdata=8'h22; repeat with rd_ack on the commit cycle -> overrun=0, data_ready=1.
REQ-032: Assert rst_n low mid-DATA of 0x5A, release, send 0xC3 -> single rx_valid, rdata=8'hC3.
REQ-033: Back-to-back bytes 0x00,0xFF,0x80 with one stop bit each -> three rx_valid pulses, correct values, no frame_err.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit
// sampling, framing-error detection with break handling, and a one-deep
// holding register (rdata / data_ready) with overrun reporting.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLK_FREQ      = 12_000_000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned CLK_COUNT_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       rd_ack,
  output logic [7:0] rdata,
  output logic       rx_valid,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned HALF_BIT = CLK_COUNT_BIT / 2;
  localparam logic [31:0] BIT_LAST  = 32'(CLK_COUNT_BIT - 1);
  localparam logic [31:0] HALF_LAST = 32'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t      state;
  logic [31:0] clk_cnt;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic        rx_meta;
  logic        rx_s;
  // prime fills with ones once the synchronizer holds real line samples;
  // armed means rx_s has been seen high since reset, so a line held low
  // across reset release is never taken for a start bit.
  logic [1:0]  prime;
  logic        armed;

  // Two-flop synchronizer on the asynchronous line, idle-high at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // Track when the synchronizer output reflects the line, then arm on high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime <= 2'b00;
      armed <= 1'b0;
    end else begin
      prime <= {prime[0], 1'b1};
      if (prime[1] && rx_s)
        armed <= 1'b1;
    end
  end

  // Receive FSM with registered outputs and the holding-register handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      clk_cnt    <= 32'd0;
      idx        <= 3'd0;
      shift      <= 8'h00;
      rdata      <= 8'h00;
      rx_valid   <= 1'b0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Consumer read; a commit below takes priority in the same cycle.
      if (rd_ack)
        data_ready <= 1'b0;

      case (state)
        IDLE: begin
          clk_cnt <= 32'd0;
          idx     <= 3'd0;
          if (armed && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= 32'd0;
            idx     <= 3'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 32'd1;
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt    <= 32'd0;
            shift[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7)
              state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 32'd1;
          end
        end

        STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= 32'd0;
            if (rx_s) begin
              rdata      <= shift;
              rx_valid   <= 1'b1;
              data_ready <= 1'b1;
              overrun    <= data_ready && !rd_ack;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 32'd1;
          end
        end

        BREAK: begin
          // Wait out a held-low line so it reports only one frame error.
          clk_cnt <= 32'd0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand-written corner sequences; a
// scoreboard queue holds the expected byte/overrun for each rx_valid.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       RX = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] rdata;
  logic       rx_valid, data_ready, frame_err, overrun, busy;

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ(12_000_000), .BAUD_RATE(115200)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .rd_ack(rd_ack), .rdata(rdata),
    .rx_valid(rx_valid), .data_ready(data_ready), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       ovr;
  } vec_t;

  exp_t sb[$];
  vec_t vt[4];
  int   n_cmp = 0, n_bad = 0, n_valid = 0, n_ferr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame starting at the next falling clock edge; the line is
  // left at the stop-bit level afterwards.
  task automatic send(input logic [7:0] d, input logic stop);
    @(negedge clk);
    RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (BIT) @(negedge clk);
    end
    RX = stop;
    repeat (BIT) @(negedge clk);
  endtask

  // Output monitor: pops the scoreboard on every rx_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        n_valid++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rx_valid: got rdata %0h with no byte expected", rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata", {24'd0, rdata}, {24'd0, e.data});
          chk("overrun", {31'd0, overrun}, {31'd0, e.ovr});
          chk("data_ready_at_commit", {31'd0, data_ready}, 32'd1);
        end
      end
      if (frame_err)
        n_ferr++;
      if ((frame_err && (rx_valid || overrun)) || (overrun && !rx_valid)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pulse_exclusive: rx_valid %0b frame_err %0b overrun %0b", rx_valid, frame_err, overrun);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev;
    int v0, f0;

    vt[0] = '{8'hA5, 1'b1, 1'b0};
    vt[1] = '{8'h00, 1'b1, 1'b1};
    vt[2] = '{8'hFF, 1'b1, 1'b1};
    vt[3] = '{8'h80, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rdata", {24'd0, rdata}, 32'h00);
    chk("rst_flags", {26'd0, rx_valid, data_ready, frame_err, overrun, busy, 1'b0}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table: A5 then back-to-back 00, FF, 80 with no reads (each overruns)
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{vt[i].data, vt[i].ovr});
      send(vt[i].data, vt[i].stop);
    end
    repeat (20) @(negedge clk);
    chk("table_valid_cnt", n_valid, 4);
    chk("table_ferr_cnt", n_ferr, 0);
    chk("table_rdata", {24'd0, rdata}, 32'h80);
    chk("table_ready", {31'd0, data_ready}, 32'd1);

    // Glitch: 20 clocks low is rejected at mid start bit
    v0 = n_valid; f0 = n_ferr;
    @(negedge clk); RX = 1'b0;
    repeat (20) @(negedge clk);
    RX = 1'b1;
    chk("glitch_busy_high", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 60 && busy; k++) @(negedge clk);
    chk("glitch_busy_low", {31'd0, busy}, 32'd0);
    chk("glitch_no_valid", n_valid, v0);
    chk("glitch_no_ferr", n_ferr, f0);

    // Framing error followed by a long break
    prev = rdata;
    send(8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    chk("break_busy", {31'd0, busy}, 32'd1);
    RX = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_cnt", n_ferr, 1);
    chk("ferr_rdata", {24'd0, rdata}, {24'd0, prev});
    chk("ferr_ready", {31'd0, data_ready}, 32'd1);
    chk("ferr_idle", {31'd0, busy}, 32'd0);
    chk("ferr_no_valid", n_valid, 4);

    // Read clears data_ready; a second read while empty is harmless
    @(negedge clk); rd_ack = 1'b1;
    @(negedge clk); rd_ack = 1'b0;
    chk("ack_clears", {31'd0, data_ready}, 32'd0);
    @(negedge clk); rd_ack = 1'b1;
    @(negedge clk); rd_ack = 1'b0;
    chk("ack_empty", {31'd0, data_ready}, 32'd0);

    // Overrun, then read strobe exactly on the commit cycle
    sb.push_back('{8'h11, 1'b0});
    send(8'h11, 1'b1);
    sb.push_back('{8'h22, 1'b1});
    send(8'h22, 1'b1);
    sb.push_back('{8'h33, 1'b0});
    fork
      send(8'h33, 1'b1);
      begin
        repeat (991) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk("commit_ack_ready", {31'd0, data_ready}, 32'd1);
    chk("commit_ack_rdata", {24'd0, rdata}, 32'h33);

    // Reset in the middle of 0x5A with the line low across release
    @(negedge clk); RX = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      RX = (i == 1);
      repeat (BIT) @(negedge clk);
    end
    RX = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_rdata", {24'd0, rdata}, 32'h00);
    chk("midrst_flags", {29'd0, data_ready, busy, rx_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("midrst_not_armed", {31'd0, busy}, 32'd0);
    RX = 1'b1;
    repeat (BIT) @(negedge clk);
    sb.push_back('{8'hC3, 1'b0});
    send(8'hC3, 1'b1);
    repeat (20) @(negedge clk);
    chk("final_valid_cnt", n_valid, 8);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_ferr_cnt", n_ferr, 1);
    chk("final_rdata", {24'd0, rdata}, 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
